// File: rtl/if_fetch_queue.sv
// Fetch front end: owns the PC, issues one fetch at a time and buffers
// returned instructions in a small FIFO that the decoder drains.
`timescale 1ns/1ps
module if_fetch_queue #(
  parameter int          DEPTH_LOG = 2,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic [31:0] clear_pc,
  output logic        if_enable,
  output logic [31:0] inst_addr,
  input  logic        if_ready,
  input  logic [31:0] inst,
  input  logic        is_c,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_is_c,
  input  logic        out_ready
);
  localparam int                DEPTH_N = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] DEPTH  = DEPTH_N[DEPTH_LOG:0];

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_c;
  } entry_t;

  typedef enum logic {IDLE, REQ} state_t;

  state_t               state;
  logic [31:0]          pc;
  entry_t               q [DEPTH_N];
  logic [DEPTH_LOG-1:0] head, tail;
  logic [DEPTH_LOG:0]   count, cnt_nxt;
  logic                 push, pop;

  assign push = (state == REQ) & if_ready;
  assign pop  = (count != '0) & out_ready;

  always_comb begin
    cnt_nxt = count;
    if (push && !pop)      cnt_nxt = count + (DEPTH_LOG+1)'(1);
    else if (!push && pop) cnt_nxt = count - (DEPTH_LOG+1)'(1);
  end

  // Dropping the request in the response cycle keeps the controller from
  // relaunching at the PC that is about to advance.
  assign if_enable = (state == REQ) & ~if_ready;
  assign inst_addr = pc;
  assign out_valid = (count != '0);
  assign out_inst  = q[head].inst;
  assign out_pc    = q[head].pc;
  assign out_is_c  = q[head].is_c;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= IDLE;
      for (int i = 0; i < DEPTH_N; i++) q[i] <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        pc    <= clear_pc;
        head  <= '0;
        tail  <= '0;
        count <= '0;
        state <= IDLE;
      end else begin
        if (push) begin
          q[tail] <= '{inst: inst, pc: pc, is_c: is_c};
          tail    <= tail + DEPTH_LOG'(1);
          pc      <= pc + (is_c ? 32'd2 : 32'd4);
        end
        if (pop) head <= head + DEPTH_LOG'(1);
        count <= cnt_nxt;
        case (state)
          IDLE: if (count < DEPTH) state <= REQ;
          REQ:  if (push) state <= (cnt_nxt == DEPTH) ? IDLE : REQ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // The in-flight slot is always reserved, so a response can never hit a full queue.
  assert property (@(posedge clk_in) disable iff (rst_in)
    !(rdy_in && if_ready && count == DEPTH));
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench: a latency-4 memory model feeds the queue and every
// decoder pop is compared against the expected fetch stream.
`timescale 1ns/1ps
module tb_if_fetch_queue;
  localparam int LAT = 4;
  localparam int DEPTH = 4;

  logic        clk_in = 0, rst_in, rdy_in, clear, if_ready, is_c, out_ready;
  logic [31:0] clear_pc, inst;
  logic        if_enable, out_valid, out_is_c;
  logic [31:0] inst_addr, out_inst, out_pc;

  if_fetch_queue #(.DEPTH_LOG(2), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .clear_pc(clear_pc), .if_enable(if_enable), .inst_addr(inst_addr),
    .if_ready(if_ready), .inst(inst), .is_c(is_c), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .out_is_c(out_is_c),
    .out_ready(out_ready)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_c;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0;
  logic        busy = 0;
  int          lat = 0;
  logic [31:0] exp_pc = 32'h0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic mem_c(input logic [31:0] a);
    return a[3:1] == 3'b100;
  endfunction

  function automatic logic [31:0] mem_inst(input logic [31:0] a);
    return mem_c(a) ? 32'h0000_4501 : (32'h13 | {a[19:0], 12'h0});
  endfunction

  // One clock of stimulus, memory model and scoreboard; returns #2 after the edge.
  task automatic cycle(input logic ordy, input logic rdy, input logic clr, input logic [31:0] cpc);
    logic resp;
    exp_t e;
    rdy_in = rdy; clear = clr; clear_pc = cpc; out_ready = ordy;
    resp = busy && lat == 0;
    if_ready = resp;
    inst = resp ? mem_inst(exp_pc) : 32'h0;
    is_c = resp ? mem_c(exp_pc) : 1'b0;
    #1;
    if (sb.size() == DEPTH) chk("full_noreq", {31'h0, if_enable}, 32'h0);
    if (rdy && !clr && out_valid && out_ready) begin
      if (sb.size() == 0) chk("pop_empty", 32'h1, 32'h0);
      else begin
        e = sb.pop_front();
        chk("out_inst", out_inst, e.inst);
        chk("out_pc", out_pc, e.pc);
        chk("out_is_c", {31'h0, out_is_c}, {31'h0, e.is_c});
      end
    end
    if (rdy) begin
      if (clr) begin
        sb.delete();
        busy = 0;
        exp_pc = cpc;
      end else if (resp) begin
        chk("en_drop", {31'h0, if_enable}, 32'h0);
        sb.push_back('{inst: inst, pc: exp_pc, is_c: is_c});
        exp_pc = exp_pc + (is_c ? 32'd2 : 32'd4);
        busy = 0;
      end else if (busy) begin
        lat--;
      end else if (if_enable) begin
        chk("inst_addr", inst_addr, exp_pc);
        busy = 1;
        lat = LAT - 1;
      end
    end
    @(posedge clk_in);
    #1;
    if_ready = 0; inst = 0; is_c = 0;
    #1;
    chk("out_valid", {31'h0, out_valid}, {31'h0, sb.size() != 0});
  endtask

  task automatic run_until_resp(input logic ordy, input int budget);
    int n = 0;
    while (!(busy && lat == 0) && n < budget) begin
      cycle(ordy, 1, 0, 0);
      n++;
    end
    if (n >= budget) chk("timeout_resp", 32'h1, 32'h0);
  endtask

  initial begin
    logic [31:0] hold_addr;
    logic        hold_vld;
    int n;
    rst_in = 1; rdy_in = 1; clear = 0; clear_pc = 0; if_ready = 0;
    inst = 0; is_c = 0; out_ready = 0;
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_en", {31'h0, if_enable}, 32'h0);
    chk("rst_addr", inst_addr, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_is_c", {31'h0, out_is_c}, 32'h0);
    rst_in = 0;

    cycle(0, 1, 0, 0);
    chk("first_req", {31'h0, if_enable}, 32'h1);
    chk("first_addr", inst_addr, 32'h0);

    // Fill with decoder stalled: pcs 0, 4, 8 (compressed), A
    n = 0;
    while (sb.size() < DEPTH && n < 200) begin cycle(0, 1, 0, 0); n++; end
    chk("fill_cnt", sb.size(), DEPTH);
    repeat (8) cycle(0, 1, 0, 0);
    chk("full_en", {31'h0, if_enable}, 32'h0);
    chk("head_inst", out_inst, 32'h13);
    chk("head_pc", out_pc, 32'h0);

    cycle(1, 1, 0, 0);
    n = 0;
    while (!if_enable && n < 20) begin cycle(0, 1, 0, 0); n++; end
    chk("refill_addr", inst_addr, 32'hE);

    repeat (60) cycle(1, 1, 0, 0);
    repeat (300) cycle(1'($urandom), ($urandom_range(0, 99) < 85), 0, 0);

    // Freeze with a response pending
    run_until_resp(1, 50);
    hold_addr = inst_addr;
    hold_vld = out_valid;
    repeat (3) cycle(0, 0, 0, 0);
    chk("frz_addr", inst_addr, hold_addr);
    chk("frz_valid", {31'h0, out_valid}, {31'h0, hold_vld});
    repeat (40) cycle(1, 1, 0, 0);

    // Clear coinciding with a response
    run_until_resp(0, 50);
    cycle(0, 1, 1, 32'h1000);
    chk("clr_valid", {31'h0, out_valid}, 32'h0);
    chk("clr_idle", {31'h0, if_enable}, 32'h0);
    cycle(0, 1, 0, 0);
    chk("clr_req", {31'h0, if_enable}, 32'h1);
    chk("clr_addr", inst_addr, 32'h1000);

    repeat (300) cycle(1'($urandom), ($urandom_range(0, 99) < 90), 0, 0);
    repeat (60) cycle(1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Instruction fetch front end: owns the PC, issues fetch requests to the memory controller and buffers returned instructions in a small FIFO.
- The decoder drains the FIFO through a valid/ready handshake.
- Handles RV32C fetches: the PC advances by 2 or 4 according to the memory controller's compressed flag.
- On a pipeline flush (clear), the queue is emptied and fetching restarts at the redirect PC.

Parameters:
- DEPTH_LOG, 2, log2 of queue depth (depth = 4 entries)
- RESET_PC, 32'h0, PC value loaded on reset

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- rdy_in  input  1  global ready; all state frozen when low
- clear  input  1  flush request, qualified by rdy_in
- clear_pc  input  32  redirect PC, valid with clear
- if_enable  output  1  fetch request to memory controller
- inst_addr  output  32  fetch address
- if_ready  input  1  one-cycle pulse: fetch data valid this cycle
- inst  input  32  fetched instruction; 16-bit value zero-extended when compressed
- is_c  input  1  fetched instruction is compressed, valid with if_ready
- out_valid  output  1  queue head valid
- out_inst  output  32  head instruction
- out_pc  output  32  PC of head instruction
- out_is_c  output  1  head instruction is compressed
- out_ready  input  1  decoder accepts head this cycle

Behaviour:
- Clock/reset: one clock, clk_in. Reset is synchronous and active-high on rst_in.
- Reset: pc = RESET_PC, head = tail = count = 0, state = IDLE. Outputs: out_valid = 0, if_enable = 0. inst_addr, out_inst, out_pc and out_is_c read 0.
- Freeze: when rdy_in = 0, no register changes. Outputs hold their previous values. if_ready and out_ready are ignored.
- Clear: rdy_in & clear has priority over everything, including rst-free operation. Effects next cycle:
  - pc = clear_pc; queue emptied (head = tail = count = 0); state = IDLE.
  - An if_ready pulse in the same cycle is discarded.
  - The memory controller aborts its own transfer on the same clear, so no stale response follows.
- FSM states:
  - IDLE: go to REQ when count + 0 < DEPTH, i.e. queue not full. At most one request is in flight, so the in-flight slot is always reserved.
  - REQ: inst_addr = pc. if_enable = (state == REQ) & ~if_ready, combinational. if_enable must drop in the if_ready cycle so the controller, which returns to idle that cycle, does not relaunch at the stale PC.
  - On if_ready in REQ:
    - Write {inst, pc, is_c} at tail; tail++.
    - pc = pc + (is_c ? 2 : 4), 32-bit wrap.
    - Next state: REQ if the queue is not full after this push, accounting for any same-cycle pop; otherwise IDLE.
- Queue:
  - out_valid = (count != 0). out_* are driven from the head entry.
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged. A pop when empty is ignored.
  - Pointers are DEPTH_LOG bits wide and wrap modulo DEPTH. count is DEPTH_LOG+1 bits wide.
- Full: count == DEPTH means no request is issued. An if_ready while full cannot occur because of the reservation rule; the assertion checker flags it.
- Latency:
  - First request: if_enable is asserted 1 cycle after reset deassert or after a clear.
  - Fetch to out_valid: the entry is visible the cycle after if_ready.
- Throughput: back-to-back requests. A new if_enable is asserted the cycle after if_ready when space remains.
- inst_addr holds pc in all states, so it is stable throughout REQ.

Test Plan:
- Reset, RESET_PC = 0, controller model returns 32'h00000013 after 4 cycles -> if_enable = 1 at cycle 1, inst_addr = 0. Entry {inst = 32'h13, pc = 0, is_c = 0} appears. Next inst_addr = 4.
- Compressed fetch: return inst = 32'h00004501 with is_c = 1 at pc = 8 -> out_pc = 8, out_is_c = 1, next inst_addr = 10 (32'hA).
- Fill: out_ready = 0, 4 fetches complete -> count = 4, if_enable stays 0. Raise out_ready for 1 cycle -> one pop, then a new request at the next PC.
- Clear with if_ready in the same cycle, clear_pc = 32'h1000 -> returned word dropped, out_valid = 0 next cycle, then if_enable with inst_addr = 32'h1000.
- Simultaneous push and pop with count = 2 -> count stays 2. Entries are dequeued in PC order 0, 4, 8, ...
- rdy_in low for 3 cycles mid-REQ while if_ready pulses -> no state change; the pulse is ignored. Resume matches the trace without the stall.
